// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/control request and result bus of the execute-stage ALU.
//   in_valid, alu_ctrl, op_a, op_b : request from the upstream decoder
//   in_ready                       : unit can take a new operation
//   out_valid                      : one-cycle completion pulse
//   result, zero, overflow,
//   illegal, div_zero, hi, lo      : registered results and flags
// The master modport drives requests; the slave modport is the ALU side.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b,
    input  in_ready, out_valid, result, zero, overflow, illegal, div_zero, hi, lo
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b,
    output in_ready, out_valid, result, zero, overflow, illegal, div_zero, hi, lo
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU.
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : alu_exec_unit_if.slave (request handshake, result, flags, HI/LO)
// Single-cycle ops complete one cycle after acceptance. MULTU (shift-add)
// and DIVU (restoring) iterate one bit per cycle for WIDTH cycles.
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | ready; single-cycle ops complete from here
// S_MUL  | MULTU iterating, {acc_hi,acc_lo} = partial product
// S_DIV  | DIVU iterating, acc_hi = remainder, acc_lo = quotient
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0] sum_w, diff_w;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge, last_iter, slt_bit;
  logic             sc_done, sc_ovf, sc_ill;
  logic [WIDTH-1:0] sc_result;

  assign sum_w  = bus.op_a + bus.op_b;
  assign diff_w = bus.op_a - bus.op_b;
  // Signed compare from the sign bits when they differ, so an overflowing
  // subtraction cannot flip the answer.
  assign slt_bit = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) ? bus.op_a[WIDTH-1]
                                                          : diff_w[WIDTH-1];

  // opr_q holds the multiplicand (MUL) or the divisor (DIV).
  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opr_q : '0)};
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opr_q});
  // When div_ge the true difference is below the divisor, so WIDTH bits suffice.
  assign div_sub   = div_shift[WIDTH-1:0] - opr_q;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opr_d       = opr_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    div_zero_d  = div_zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    sc_done     = 1'b0;
    sc_ovf      = 1'b0;
    sc_ill      = 1'b0;
    sc_result   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          case (bus.alu_ctrl)
            OP_ADD: begin
              sc_done   = 1'b1;
              sc_result = sum_w;
              sc_ovf    = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_SUB: begin
              sc_done   = 1'b1;
              sc_result = diff_w;
              sc_ovf    = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                          (diff_w[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_AND: begin
              sc_done   = 1'b1;
              sc_result = bus.op_a & bus.op_b;
            end
            OP_OR: begin
              sc_done   = 1'b1;
              sc_result = bus.op_a | bus.op_b;
            end
            OP_NOR: begin
              sc_done   = 1'b1;
              sc_result = ~(bus.op_a | bus.op_b);
            end
            OP_SLT: begin
              sc_done   = 1'b1;
              sc_result = {{(WIDTH-1){1'b0}}, slt_bit};
            end
            OP_MULTU: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              acc_hi_d = '0;
              acc_lo_d = bus.op_b;
              opr_d    = bus.op_a;
            end
            OP_DIVU: begin
              if (bus.op_b == '0) begin
                out_valid_d = 1'b1;
                result_d    = '1;
                zero_d      = 1'b0;
                overflow_d  = 1'b0;
                illegal_d   = 1'b0;
                div_zero_d  = 1'b1;
                hi_d        = bus.op_a;
                lo_d        = '1;
              end else begin
                state_d  = S_DIV;
                cnt_d    = '0;
                acc_hi_d = '0;
                acc_lo_d = bus.op_a;
                opr_d    = bus.op_b;
              end
            end
            default: begin
              sc_done = 1'b1;
              sc_ill  = 1'b1;
            end
          endcase
        end
        if (sc_done) begin
          out_valid_d = 1'b1;
          result_d    = sc_result;
          zero_d      = (sc_result == '0);
          overflow_d  = sc_ovf;
          illegal_d   = sc_ill;
          div_zero_d  = 1'b0;
        end
      end

      S_MUL: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          hi_d        = acc_hi_d;
          lo_d        = acc_lo_d;
          result_d    = acc_lo_d;
          zero_d      = (acc_hi_d == '0) && (acc_lo_d == '0);
          overflow_d  = 1'b0;
          illegal_d   = 1'b0;
          div_zero_d  = 1'b0;
        end
      end

      S_DIV: begin
        acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          hi_d        = acc_hi_d;
          lo_d        = acc_lo_d;
          result_d    = acc_lo_d;
          zero_d      = (acc_lo_d == '0);
          overflow_d  = 1'b0;
          illegal_d   = 1'b0;
          div_zero_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opr_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opr_q       <= opr_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      div_zero_q  <= div_zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table of operations driven through the request handshake,
// expected results queued on acceptance and compared on each out_valid pulse,
// plus hand-written sequences for MULTU stall, back-to-back issue and reset abort.
module tb_alu_exec_unit;
  localparam int W = 32;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100,
                         C_MUL = 4'b1000, C_DIV = 4'b1001, C_BAD = 4'b1111;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         il;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    longint       t_acc;
  } vec_t;

  logic clk;
  logic rst;
  alu_exec_unit_if #(.WIDTH(W)) bus();
  alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ov_count = 0;
  vec_t sb_q[$];
  vec_t mon_e;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every out_valid pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      ov_count++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no completion at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("result[%0h]", mon_e.ctrl), {32'b0, bus.result}, {32'b0, mon_e.res});
        chk($sformatf("flags_z_ov_il_dz[%0h]", mon_e.ctrl),
            {60'b0, bus.zero, bus.overflow, bus.illegal, bus.div_zero},
            {60'b0, mon_e.z, mon_e.ov, mon_e.il, mon_e.dz});
        chk($sformatf("hi[%0h]", mon_e.ctrl), {32'b0, bus.hi}, {32'b0, mon_e.hi});
        chk($sformatf("lo[%0h]", mon_e.ctrl), {32'b0, bus.lo}, {32'b0, mon_e.lo});
        chk($sformatf("latency[%0h]", mon_e.ctrl),
            64'(($time - mon_e.t_acc + 5) / 10), 64'(mon_e.lat));
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with in_valid still high.
  task automatic send(input vec_t v);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.alu_ctrl = v.ctrl;
    bus.op_a     = v.a;
    bus.op_b     = v.b;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", {63'b0, bus.in_ready}, 64'd1);
    if (v.ctrl == C_MUL || v.ctrl == C_DIV) begin
      model_hi = v.hi;
      model_lo = v.lo;
    end else begin
      v.hi = model_hi;
      v.lo = model_lo;
    end
    v.t_acc = longint'($time) + 5;
    sb_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic z, input logic ov,
                              input logic il, input logic dz, input logic [W-1:0] h,
                              input logic [W-1:0] l, input int lat);
    vec_t v;
    v.ctrl = c; v.a = a; v.b = b; v.res = r; v.z = z; v.ov = ov; v.il = il; v.dz = dz;
    v.hi = h; v.lo = l; v.lat = lat; v.t_acc = 0;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int low;
    int saved;
    int waited;
    logic ov1, ov2, ov3, ov4;

    tbl.push_back(mk(C_ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_SUB, 32'd5,        32'd5,        32'h0,        1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_SLT, 32'h80000000, 32'h1,        32'h1,        0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_SLT, 32'h1,        32'h80000000, 32'h0,        1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_SLT, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_SUB, 32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_ADD, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_NOR, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_BAD, 32'h1234,     32'h5678,     32'h0,        1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(C_DIV, 32'd100,      32'd7,        32'd14,       0, 0, 0, 0, 32'd2, 32'd14, 33));
    tbl.push_back(mk(C_DIV, 32'd9,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1, 32'd9, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(C_MUL, 32'h10000,    32'h10000,    32'h0,        0, 0, 0, 0, 32'h1, 32'h0, 33));
    tbl.push_back(mk(C_DIV, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 0, 0, 0, 0, 32'hF, 32'h0FFFFFFF, 33));
    tbl.push_back(mk(C_ADD, 32'd3,        32'd4,        32'd7,        0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(C_MUL, 32'h0,        32'd5,        32'h0,        1, 0, 0, 0, 32'h0, 32'h0, 33));
    tbl.push_back(mk(C_SUB, 32'h0,        32'h80000000, 32'h80000000, 0, 1, 0, 0, 0, 0, 1));

    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_result", {32'b0, bus.result}, 64'd0);
    chk("rst_flags", {60'b0, bus.zero, bus.overflow, bus.illegal, bus.div_zero}, 64'd0);
    chk("rst_hi_lo", {bus.hi, bus.lo}, 64'd0);

    // Table issued back-to-back; multi-cycle entries stall the following one.
    foreach (tbl[i]) send(tbl[i]);
    bus.in_valid = 1'b0;
    repeat (40) @(negedge clk);

    // Three single-cycle ops one per cycle: out_valid high three cycles running.
    send(mk(C_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0, 0, 0, 1));
    ov1 = bus.out_valid;
    send(mk(C_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 0, 0, 0, 0, 1));
    ov2 = bus.out_valid;
    send(mk(C_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1));
    ov3 = bus.out_valid;
    bus.in_valid = 1'b0;
    @(negedge clk);
    ov4 = bus.out_valid;
    chk("b2b_out_valid_run", {60'b0, ov1, ov2, ov3, ov4}, 64'b1110);

    // MULTU with in_valid held through the stall; must complete exactly once.
    saved = ov_count;
    send(mk(C_MUL, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 0, 0, 0, 0, 32'h1, 32'hFFFFFFFE, 33));
    low = 0;
    while (!bus.in_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("mul_in_ready_low_cycles", 64'(low), 64'd32);
    repeat (5) @(negedge clk);
    chk("mul_single_completion", 64'(ov_count - saved), 64'd1);

    // Reset in the middle of a MULTU: no completion, HI/LO cleared.
    bus.in_valid = 1'b1;
    bus.alu_ctrl = C_MUL;
    bus.op_a = 32'd3;
    bus.op_b = 32'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {63'b0, bus.in_ready}, 64'd0);
    saved = ov_count;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("post_reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
    repeat (40) @(negedge clk);
    chk("reset_abort_no_out_valid", 64'(ov_count - saved), 64'd0);
    chk("post_reset_hi_lo_hold", {bus.hi, bus.lo}, 64'd0);

    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that sits directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus two register operands and produces the result, zero and overflow flags.
- Single-cycle ops (ADD/SUB/AND/OR/SLT/NOR) complete with 1-cycle latency. Iterative ops (MULTU, DIVU) take WIDTH cycles and write the HI/LO registers.
- A valid/ready handshake lets the datapath stall on multi-cycle operations.

Parameters:
- WIDTH, 32, operand/result width in bits; also the iteration count for MULTU/DIVU.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
- in_valid  input  1  operands and control code present this cycle.
- in_ready  output  1  unit can accept an operation.
- alu_ctrl  input  4  operation code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT, 1100 NOR, 1000 MULTU, 1001 DIVU.
- op_a  input  WIDTH  operand A (rs).
- op_b  input  WIDTH  operand B (rt or immediate).
- out_valid  output  1  one-cycle pulse: result, flags and HI/LO are valid.
- result  output  WIDTH  ALU result; LO value for MULTU/DIVU.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (ADD/SUB only).
- illegal  output  1  unrecognised alu_ctrl on the completed operation.
- div_zero  output  1  DIVU with op_b == 0.
- hi  output  WIDTH  HI register (MULTU upper product / DIVU remainder).
- lo  output  WIDTH  LO register (MULTU lower product / DIVU quotient).

Behaviour:
- Reset (rst == 0 at a clock edge):
  - State goes to IDLE; in_ready=1 from the next cycle.
  - out_valid, result, zero, overflow, illegal, div_zero, hi and lo are all cleared to 0.
  - Iteration counter is cleared to 0.
  - Reset mid-MUL/DIV aborts the operation with no out_valid and no HI/LO update.
- States: IDLE, MUL, DIV.
  - in_ready = 1 only in IDLE.
  - An operation is accepted when in_valid && in_ready at a rising edge; inputs are ignored otherwise.
- Single-cycle ops, accepted in cycle N:
  - out_valid=1 in cycle N+1, holding result and flags; state stays IDLE.
  - Back-to-back single-cycle ops are accepted every cycle.
  - ADD/SUB: result modulo 2^WIDTH; overflow = signed overflow (operand signs equal and result sign differs, with B inverted for SUB).
  - SLT: result = 1 if op_a < op_b as signed, else 0. Computed correctly even when a - op_b overflows; overflow=0.
  - AND/OR/NOR: bitwise; overflow=0.
  - Unknown code: result=0, zero=1, illegal=1, overflow=0.
- MULTU (unsigned shift-add):
  - Acceptance latches the operands and moves to MUL with counter=0; one bit is processed per cycle.
  - After WIDTH iterations, returns to IDLE with out_valid=1.
  - Then {hi,lo} = op_a*op_b; result = lo; zero = (hi==0 && lo==0).
  - Total latency from acceptance to out_valid: WIDTH+1 cycles.
- DIVU (restoring, unsigned):
  - Same timing as MULTU; lo = quotient, hi = remainder, result = lo.
  - op_b == 0: no iterations; out_valid in N+1 with lo = all ones, hi = op_a, div_zero=1.
- Flag and HI/LO holding:
  - Flags and result hold their values after the out_valid pulse until the next completion.
  - out_valid is a single-cycle pulse; there is no output back-pressure.
  - hi/lo change only on MULTU/DIVU completion.
- Multi-cycle stall: in_valid asserted while busy is ignored; upstream must hold the operation until in_ready=1.

Test Plan:
- Reset: rst=0 for 2 cycles during a MULTU in progress -> out_valid never pulses; hi=lo=0; in_ready=1 on the cycle after rst returns to 1.
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, zero=0, out_valid 1 cycle after acceptance.
- SUB 5-5 -> result 0, zero=1. SLT 0x80000000 vs 0x00000001 -> result 1, with no false result from overflow.
- Back-to-back AND/OR/NOR, one per cycle:
  - AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
  - OR of the same operands -> 0xFFF0FFF0.
  - NOR 0 with 0 -> 0xFFFFFFFF.
  - out_valid stays high for 3 consecutive cycles.
- MULTU 0xFFFFFFFF * 0x00000002 -> in_ready low for 32 cycles; out_valid at acceptance+33; hi=0x00000001, lo=0xFFFFFFFE. in_valid held during busy is not accepted twice.
- DIVU 100/7 -> lo=14, hi=2 after 33 cycles. DIVU 9/0 -> next cycle lo=0xFFFFFFFF, hi=9, div_zero=1. Code 1111 -> illegal=1, result=0.
